// File: rtl/seg_pkg.sv
// Shared definitions for the segment stimulus blocks: FSM states, digit-to-segment LUT, LFSR taps.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } seg_state_e;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register:
    // feedback = s[7]^s[5]^s[4]^s[3].
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Pattern bit order is gfedcba (bit0 = segment a). Non-decimal codes blank the display.
    function automatic logic [6:0] seg_lut(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), one shift per enabled cycle.
// Latency: state reflects the shift one cycle after en.
// Backpressure: none; en=0 freezes the sequence.
// Ports: clk, rst_n (async active-low, loads SEED), en (shift enable), state (current value).
module seg_lfsr8
    import seg_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] state
);

    logic [7:0] r_state;
    logic       w_fb;

    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (en) begin
            r_state <= {r_state[6:0], w_fb};
        end
    end

    assign state = r_state;

endmodule

// File: rtl/seg_pattern_gen.sv
// 7-segment digit pattern generator with labels and optional single-segment LFSR noise.
// Latency: 1 cycle from request transfer (or sweep step) to registered pattern + seg_valid pulse.
// Backpressure: in_ready low while a pattern is held (HOLD_CYCLES enabled cycles); ena=0 freezes everything.
// Ports: clk/rst_n; ena; in_valid/in_ready/in_digit request; sweep_en; noise_en/noise_thresh;
//        seg_out/seg_valid/seg_digit/seg_noisy/err registered pattern outputs.
module seg_pattern_gen
    import seg_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_digit,
    input  logic       sweep_en,
    input  logic       noise_en,
    input  logic [7:0] noise_thresh,
    output logic [6:0] seg_out,
    output logic       seg_valid,
    output logic [3:0] seg_digit,
    output logic       seg_noisy,
    output logic       err
);

    localparam int unsigned   CW        = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD_CYCLES - 1);

    seg_state_e    r_state;
    logic [CW-1:0] r_hold_cnt;
    logic [6:0]    r_seg_out;
    logic          r_seg_valid;
    logic [3:0]    r_seg_digit;
    logic          r_seg_noisy;
    logic          r_err;

    logic [7:0]    w_lfsr;
    logic          w_idle;
    logic          w_accept;
    logic          w_sweep_start;
    logic          w_hold_end;
    logic          w_sweep_next;
    logic          w_load;
    logic [3:0]    w_next_digit;
    logic [3:0]    w_load_digit;
    logic          w_illegal;
    logic          w_flip;
    logic [2:0]    w_flip_idx;
    logic [6:0]    w_flip_mask;

    // Noise source; its value before this cycle's shift is what a load sees.
    seg_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena),
        .state (w_lfsr)
    );

    assign w_idle        = (r_state == ST_IDLE);
    assign in_ready      = ena & w_idle;
    assign w_accept      = in_valid & in_ready;
    // Explicit requests win over the autonomous sweep.
    assign w_sweep_start = ena & w_idle & ~in_valid & sweep_en;
    assign w_hold_end    = ena & (r_state == ST_HOLD) & (r_hold_cnt == CNT_LAST);
    assign w_sweep_next  = w_hold_end & sweep_en;
    assign w_load        = w_accept | w_sweep_start | w_sweep_next;

    // An illegal label (from a request) still restarts the sweep at 0.
    assign w_next_digit  = (r_seg_digit >= 4'd9) ? 4'd0 : r_seg_digit + 4'd1;
    assign w_load_digit  = w_accept      ? in_digit :
                           w_sweep_start ? 4'd0     : w_next_digit;
    assign w_illegal     = (w_load_digit > 4'd9);

    // Index 7 does not exist on a 7-segment pattern, so it folds onto segment a.
    assign w_flip        = noise_en & ~w_illegal & (w_lfsr < noise_thresh);
    assign w_flip_idx    = (w_lfsr[2:0] == 3'd7) ? 3'd0 : w_lfsr[2:0];
    assign w_flip_mask   = w_flip ? (7'd1 << w_flip_idx) : 7'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept || w_sweep_start) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == CNT_LAST) begin
                        r_hold_cnt <= '0;
                        if (!sweep_en) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_out   <= SEG_BLANK;
            r_seg_valid <= 1'b0;
            r_seg_digit <= 4'd0;
            r_seg_noisy <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // w_load already includes ena, so the pulse is also suppressed while frozen.
            r_seg_valid <= w_load;
            if (w_load) begin
                r_seg_out   <= seg_lut(w_load_digit) ^ w_flip_mask;
                r_seg_digit <= w_load_digit;
                r_seg_noisy <= w_flip;
                r_err       <= w_illegal;
            end
        end
    end

    assign seg_out   = r_seg_out;
    assign seg_valid = r_seg_valid;
    assign seg_digit = r_seg_digit;
    assign seg_noisy = r_seg_noisy;
    assign err       = r_err;

endmodule

// File: tb/tb_seg_pattern_gen.sv
module tb_seg_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_digit;
    logic       sweep_en;
    logic       noise_en;
    logic [7:0] noise_thresh;
    logic [6:0] seg_out;
    logic       seg_valid;
    logic [3:0] seg_digit;
    logic       seg_noisy;
    logic       err;

    // Second instance with the short hold used for the sweep-wrap test.
    logic       ena2;
    logic       in_valid2;
    logic       in_ready2;
    logic [3:0] in_digit2;
    logic       sweep2;
    logic       noise_en2;
    logic [7:0] thresh2;
    logic [6:0] seg_out2;
    logic       seg_valid2;
    logic [3:0] seg_digit2;
    logic       seg_noisy2;
    logic       err2;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;

    seg_pattern_gen #(.HOLD_CYCLES(4), .LFSR_SEED(8'hA5)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .in_digit(in_digit), .sweep_en(sweep_en), .noise_en(noise_en), .noise_thresh(noise_thresh),
        .seg_out(seg_out), .seg_valid(seg_valid), .seg_digit(seg_digit), .seg_noisy(seg_noisy),
        .err(err)
    );

    seg_pattern_gen #(.HOLD_CYCLES(2), .LFSR_SEED(8'hA5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_digit(in_digit2), .sweep_en(sweep2), .noise_en(noise_en2), .noise_thresh(thresh2),
        .seg_out(seg_out2), .seg_valid(seg_valid2), .seg_digit(seg_digit2), .seg_noisy(seg_noisy2),
        .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)   m_lfsr <= 8'hA5;
        else if (ena) m_lfsr <= lfsr_step(m_lfsr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with dut1 idle; returns after the transfer edge.
    task automatic req(input logic [3:0] d, output logic [7:0] pre);
        in_valid = 1'b1;
        in_digit = d;
        pre      = m_lfsr;
        tick();
        in_valid = 1'b0;
        in_digit = 4'h0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [3:0] digit;
        logic       nen;
        logic [7:0] thr;
        logic [6:0] exp_seg;
        logic       exp_err;
    } vec_t;

    vec_t       vecs[14];
    logic [6:0] exp_lut[10];
    logic [7:0] pre;
    logic [6:0] exp_seg;
    logic [6:0] held;
    logic [2:0] idx;

    initial begin
        vecs[0]  = '{4'd0,  1'b0, 8'd0,   7'h3F, 1'b0};
        vecs[1]  = '{4'd1,  1'b0, 8'd0,   7'h06, 1'b0};
        vecs[2]  = '{4'd2,  1'b0, 8'd0,   7'h5B, 1'b0};
        vecs[3]  = '{4'd3,  1'b0, 8'd0,   7'h4F, 1'b0};
        vecs[4]  = '{4'd4,  1'b0, 8'd0,   7'h66, 1'b0};
        vecs[5]  = '{4'd5,  1'b0, 8'd0,   7'h6D, 1'b0};
        vecs[6]  = '{4'd6,  1'b0, 8'd0,   7'h7D, 1'b0};
        vecs[7]  = '{4'd7,  1'b0, 8'd0,   7'h07, 1'b0};
        vecs[8]  = '{4'd8,  1'b0, 8'd0,   7'h7F, 1'b0};
        vecs[9]  = '{4'd9,  1'b0, 8'd0,   7'h6F, 1'b0};
        vecs[10] = '{4'd10, 1'b0, 8'd0,   7'h00, 1'b1};
        vecs[11] = '{4'd12, 1'b1, 8'd255, 7'h00, 1'b1};
        vecs[12] = '{4'd15, 1'b1, 8'd255, 7'h00, 1'b1};
        vecs[13] = '{4'd5,  1'b1, 8'd0,   7'h6D, 1'b0};
        exp_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_digit = 4'h0; sweep_en = 1'b0;
        noise_en = 1'b0; noise_thresh = 8'd0;
        ena2 = 1'b0; in_valid2 = 1'b0; in_digit2 = 4'h0; sweep2 = 1'b0;
        noise_en2 = 1'b0; thresh2 = 8'd0;

        // Reset / idle
        repeat (3) tick();
        chk("rst_seg_out", {25'd0, seg_out}, 32'h0);
        chk("rst_seg_valid", {31'd0, seg_valid}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_seg_valid", {31'd0, seg_valid}, 32'd0);
            chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
            chk("idle_outs", {seg_out, seg_digit, seg_noisy, err}, 32'd0);
        end

        // Direct request: digit 3, hold of 4 cycles
        req(4'd3, pre);
        chk("req3_valid", {31'd0, seg_valid}, 32'd1);
        chk("req3_seg", {25'd0, seg_out}, 32'h4F);
        chk("req3_digit", {28'd0, seg_digit}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("req3_ready_low", {31'd0, in_ready}, 32'd0);
            tick();
            if (i < 3) chk("req3_valid_once", {31'd0, seg_valid}, 32'd0);
        end
        chk("req3_ready_back", {31'd0, in_ready}, 32'd1);
        chk("req3_seg_held", {25'd0, seg_out}, 32'h4F);

        // Table of single requests
        for (int v = 0; v < 14; v++) begin
            noise_en     = vecs[v].nen;
            noise_thresh = vecs[v].thr;
            req(vecs[v].digit, pre);
            chk("tbl_valid", {31'd0, seg_valid}, 32'd1);
            chk("tbl_seg", {25'd0, seg_out}, {25'd0, vecs[v].exp_seg});
            chk("tbl_digit", {28'd0, seg_digit}, {28'd0, vecs[v].digit});
            chk("tbl_err", {31'd0, err}, {31'd0, vecs[v].exp_err});
            chk("tbl_noisy", {31'd0, seg_noisy}, 32'd0);
            wait_ready();
        end

        // Noise case 1: threshold 255, digit 8, flip predicted from reference LFSR
        noise_en = 1'b1; noise_thresh = 8'd255;
        for (int k = 0; k < 8; k++) begin
            req(4'd8, pre);
            idx     = (pre[2:0] == 3'd7) ? 3'd0 : pre[2:0];
            exp_seg = (pre != 8'hFF) ? (7'h7F ^ (7'd1 << idx)) : 7'h7F;
            chk("noise_seg", {25'd0, seg_out}, {25'd0, exp_seg});
            chk("noise_flag", {31'd0, seg_noisy}, {31'd0, pre != 8'hFF});
            chk("noise_onebit", $countones(seg_out ^ 7'h7F), {31'd0, pre != 8'hFF});
            wait_ready();
        end

        // Noise case 2: threshold 0 never flips
        noise_thresh = 8'd0;
        for (int k = 0; k < 100; k++) begin
            req(4'd8, pre);
            chk("nonoise_seg", {25'd0, seg_out}, 32'h7F);
            chk("nonoise_flag", {31'd0, seg_noisy}, 32'd0);
            wait_ready();
        end
        noise_en = 1'b0;

        // Request wins over sweep, then the sweep continues from the requested digit
        sweep_en = 1'b1;
        req(4'd5, pre);
        chk("prio_digit", {28'd0, seg_digit}, 32'd5);
        chk("prio_seg", {25'd0, seg_out}, 32'h6D);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("prio_gap", {31'd0, seg_valid}, 32'd0);
        end
        tick();
        chk("prio_next_valid", {31'd0, seg_valid}, 32'd1);
        chk("prio_next_digit", {28'd0, seg_digit}, 32'd6);
        chk("prio_next_seg", {25'd0, seg_out}, 32'h7D);
        sweep_en = 1'b0;
        wait_ready();
        chk("prio_end_digit", {28'd0, seg_digit}, 32'd6);

        // Sweep wrap on the HOLD_CYCLES=2 instance
        ena2 = 1'b1; sweep2 = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("sweep_valid", {31'd0, seg_valid2}, 32'd1);
            chk("sweep_digit", {28'd0, seg_digit2}, k % 10);
            chk("sweep_seg", {25'd0, seg_out2}, {25'd0, exp_lut[k % 10]});
            tick();
            chk("sweep_gap", {31'd0, seg_valid2}, 32'd0);
        end
        sweep2 = 1'b0;
        tick();
        chk("sweep_stop_valid", {31'd0, seg_valid2}, 32'd0);
        chk("sweep_stop_ready", {31'd0, in_ready2}, 32'd1);
        chk("sweep_stop_digit", {28'd0, seg_digit2}, 32'd0);
        ena2 = 1'b0;

        // Freeze mid-hold for 5 cycles
        req(4'd2, pre);
        chk("frz_valid", {31'd0, seg_valid}, 32'd1);
        tick();
        ena = 1'b0;
        held = seg_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_ready", {31'd0, in_ready}, 32'd0);
            chk("frz_pulse", {31'd0, seg_valid}, 32'd0);
            chk("frz_seg", {25'd0, seg_out}, {25'd0, held});
        end
        ena = 1'b1;
        tick();
        tick();
        chk("frz_still_hold", {31'd0, in_ready}, 32'd0);
        tick();
        chk("frz_release", {31'd0, in_ready}, 32'd1);
        chk("frz_seg_final", {25'd0, seg_out}, 32'h5B);
        // LFSR must have stalled along with the model
        noise_en = 1'b1; noise_thresh = 8'd255;
        req(4'd0, pre);
        idx     = (pre[2:0] == 3'd7) ? 3'd0 : pre[2:0];
        exp_seg = (pre != 8'hFF) ? (7'h3F ^ (7'd1 << idx)) : 7'h3F;
        chk("frz_lfsr_seg", {25'd0, seg_out}, {25'd0, exp_seg});
        wait_ready();
        noise_en = 1'b0; noise_thresh = 8'd0;

        // Reset pulsed mid-hold
        req(4'd7, pre);
        chk("rsth_seg", {25'd0, seg_out}, 32'h07);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rsth_async_seg", {25'd0, seg_out}, 32'h0);
        chk("rsth_async_outs", {seg_valid, seg_digit, seg_noisy, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rsth_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rsth_no_pulse", {31'd0, seg_valid}, 32'd0);
            chk("rsth_seg_zero", {25'd0, seg_out}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
